// File: rtl/hms_pkg.sv
// Shared definitions for the hour/minute/second timekeeper: mode encodings and field widths.
package hms_pkg;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_SET_A = 2'b01;
    localparam logic [1:0] MODE_SET_B = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    localparam int SEC_W  = 6;
    localparam int HOUR_W = 5;

    function automatic logic is_set_mode(input logic [1:0] mode);
        return (mode == MODE_SET_A) || (mode == MODE_SET_B);
    endfunction

endpackage

// File: rtl/hms_field_cnt.sv
// One time field: a mod-(MAX+1) counter with range-checked load, clear and a terminal-count flag.
module hms_field_cnt
    import hms_pkg::*;
#(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    input  logic             clear,
    output logic [W-1:0]     value,
    output logic             at_max,
    output logic             reject
);

    logic in_range;

    // Compare the full 6-bit load value so a narrower field also rejects any set upper bit.
    assign in_range = (load_val <= SEC_W'(MAX));
    assign at_max   = (value == W'(MAX));
    assign reject   = load && !in_range;

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load && in_range) begin
            value <= load_val[W-1:0];
        end else if (inc) begin
            value <= at_max ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/hms_timekeeper.sv
// Running hh:mm:ss registers with run/set/clear modes and a day-wrap pulse.
// Optional hourly chime output when HMS_HOURLY_CHIME_EN is defined.
module hms_timekeeper
    import hms_pkg::*;
#(
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        state,
    input  logic [SEC_W-1:0]  num,
    input  logic              sec_enable,
    input  logic              min_enable,
    input  logic              hour_enable,
    output logic [SEC_W-1:0]  sec,
    output logic [SEC_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              day_carry,
`ifdef HMS_HOURLY_CHIME_EN
    output logic              chime,
`endif
    output logic              set_err
);

    logic [1:0] mode_q;
    logic       run_mode, set_mode, clr_mode;
    logic       sec_inc, min_inc, hour_inc, day_wrap;
    logic       sec_tc, min_tc, hour_tc;
    logic       sec_rej, min_rej, hour_rej;

    // Mode is registered so every decision lags a state change by one clk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= state;
        end
    end

    assign run_mode = (mode_q == MODE_RUN);
    assign set_mode = is_set_mode(mode_q);
    assign clr_mode = (mode_q == MODE_CLEAR);

    assign sec_inc  = run_mode && tick;
    assign min_inc  = sec_inc && sec_tc;
    assign hour_inc = min_inc && min_tc;
    assign day_wrap = hour_inc && hour_tc;

    hms_field_cnt #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_inc),
        .load     (set_mode && sec_enable),
        .load_val (num),
        .clear    (clr_mode),
        .value    (sec),
        .at_max   (sec_tc),
        .reject   (sec_rej)
    );

    hms_field_cnt #(.W(SEC_W), .MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_inc),
        .load     (set_mode && min_enable),
        .load_val (num),
        .clear    (clr_mode),
        .value    (min),
        .at_max   (min_tc),
        .reject   (min_rej)
    );

    hms_field_cnt #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      (hour_inc),
        .load     (set_mode && hour_enable),
        .load_val (num),
        .clear    (clr_mode),
        .value    (hour),
        .at_max   (hour_tc),
        .reject   (hour_rej)
    );

    // Status pulses are registered so they line up with the field values they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            day_carry <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            day_carry <= day_wrap;
            set_err   <= sec_rej || min_rej || hour_rej;
        end
    end

`ifdef HMS_HOURLY_CHIME_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            chime <= 1'b0;
        end else begin
            chime <= hour_inc;
        end
    end
`endif

endmodule

// File: tb/tb_hms_timekeeper.sv
// Randomised and directed bench for hms_timekeeper against a total-seconds reference model.
module tb_hms_timekeeper;

    localparam int SM       = 59;
    localparam int MM       = 59;
    localparam int HM       = 23;
    localparam int MINLEN   = SM + 1;
    localparam int HOURLEN  = (SM + 1) * (MM + 1);
    localparam int FULL     = HOURLEN * (HM + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] state = 2'b00;
    logic [5:0] num = 6'd0;
    logic       sec_enable = 1'b0;
    logic       min_enable = 1'b0;
    logic       hour_enable = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       day_carry;
    logic       set_err;
`ifdef HMS_HOURLY_CHIME_EN
    logic       chime;
`endif

    hms_timekeeper #(.SEC_MAX(SM), .MIN_MAX(MM), .HOUR_MAX(HM)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .state       (state),
        .num         (num),
        .sec_enable  (sec_enable),
        .min_enable  (min_enable),
        .hour_enable (hour_enable),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .day_carry   (day_carry),
`ifdef HMS_HOURLY_CHIME_EN
        .chime       (chime),
`endif
        .set_err     (set_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time of day as a single count of seconds since midnight.
    int         m_t = 0;
    logic [1:0] m_mode = 2'b00;
    logic       m_dc = 1'b0;
    logic       m_err = 1'b0;
    logic       m_chime = 1'b0;

    logic [18:0] dut_vec;
    assign dut_vec = {sec, min, hour, day_carry, set_err};

    function automatic logic [18:0] exp_vec();
        int s, m, h;
        s = m_t % MINLEN;
        m = (m_t / MINLEN) % (MM + 1);
        h = m_t / HOURLEN;
        return {6'(s), 6'(m), 5'(h), m_dc, m_err};
    endfunction

    task automatic cycle(input logic r, input logic tk, input logic [1:0] st,
                         input logic [5:0] n, input logic se, input logic me, input logic he);
        int s, m, h;
        rst = r; tick = tk; state = st; num = n;
        sec_enable = se; min_enable = me; hour_enable = he;
        @(posedge clk);
        if (!r) begin
            m_t = 0; m_dc = 0; m_err = 0; m_chime = 0; m_mode = 2'b00;
        end else begin
            m_dc = 0; m_err = 0; m_chime = 0;
            case (m_mode)
                2'b00: if (tk) begin
                    m_t = m_t + 1;
                    if (m_t % HOURLEN == 0) m_chime = 1;
                    if (m_t == FULL) begin
                        m_t = 0;
                        m_dc = 1;
                    end
                end
                2'b11: m_t = 0;
                default: begin
                    s = m_t % MINLEN;
                    m = (m_t / MINLEN) % (MM + 1);
                    h = m_t / HOURLEN;
                    if (se) begin
                        if (int'(n) <= SM) s = int'(n); else m_err = 1;
                    end
                    if (me) begin
                        if (int'(n) <= MM) m = int'(n); else m_err = 1;
                    end
                    if (he) begin
                        if (int'(n) <= HM) h = int'(n); else m_err = 1;
                    end
                    m_t = h * HOURLEN + m * MINLEN + s;
                end
            endcase
            m_mode = st;
        end
        #1;
    endtask

    task automatic load_time(input int h, input int m, input int s);
        cycle(1, 0, 2'b01, 6'd0, 0, 0, 0);
        cycle(1, 0, 2'b01, 6'(h), 0, 0, 1);
        cycle(1, 0, 2'b01, 6'(m), 0, 1, 0);
        cycle(1, 0, 2'b01, 6'(s), 1, 0, 0);
    endtask

    task automatic test_reset();
        cycle(0, 1, 2'b01, 6'd45, 1, 1, 1);
        cycle(0, 1, 2'b10, 6'd12, 1, 0, 1);
        n_vec++;
        if (dut_vec !== 19'd0) begin
            n_err++;
            $display("FAIL reset_state got %h want %h", dut_vec, 19'd0);
        end
        cycle(1, 0, 2'b11, 6'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 2'b11, 6'd7, 1, 1, 1);
        n_vec++;
        if (dut_vec !== exp_vec() || dut_vec !== 19'd0) begin
            n_err++;
            $display("FAIL clear_ticks got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_rollover();
        load_time(23, 59, 58);
        cycle(1, 0, 2'b00, 6'd0, 0, 0, 0);
        cycle(1, 1, 2'b00, 6'd0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || sec !== 6'd59 || hour !== 5'd23) begin
            n_err++;
            $display("FAIL rollover_235959 got %h want %h", dut_vec, exp_vec());
        end
        cycle(1, 1, 2'b00, 6'd0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || day_carry !== 1'b1) begin
            n_err++;
            $display("FAIL rollover_midnight got %h want %h", dut_vec, exp_vec());
        end
`ifdef HMS_HOURLY_CHIME_EN
        n_vec++;
        if (chime !== 1'b1) begin
            n_err++;
            $display("FAIL rollover_chime got %b want 1", chime);
        end
`endif
        cycle(1, 0, 2'b00, 6'd0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || day_carry !== 1'b0) begin
            n_err++;
            $display("FAIL rollover_pulse_end got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_pause();
        load_time(10, 20, 30);
        cycle(1, 0, 2'b00, 6'd0, 0, 0, 0);
        cycle(1, 0, 2'b01, 6'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 2'b01, 6'd3, 0, 0, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || sec !== 6'd30) begin
            n_err++;
            $display("FAIL pause_hold got %h want %h", dut_vec, exp_vec());
        end
        cycle(1, 0, 2'b00, 6'd0, 0, 0, 0);
        cycle(1, 1, 2'b00, 6'd0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || sec !== 6'd31 || min !== 6'd20 || hour !== 5'd10) begin
            n_err++;
            $display("FAIL pause_resume got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_range();
        cycle(1, 0, 2'b10, 6'd0, 0, 0, 0);
        cycle(1, 0, 2'b10, 6'd60, 1, 0, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || set_err !== 1'b1) begin
            n_err++;
            $display("FAIL range_sec60 got %h want %h", dut_vec, exp_vec());
        end
        cycle(1, 0, 2'b10, 6'd24, 0, 0, 1);
        n_vec++;
        if (dut_vec !== exp_vec() || set_err !== 1'b1) begin
            n_err++;
            $display("FAIL range_hour24 got %h want %h", dut_vec, exp_vec());
        end
        cycle(1, 0, 2'b10, 6'd59, 0, 1, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || set_err !== 1'b0 || min !== 6'd59) begin
            n_err++;
            $display("FAIL range_min59 got %h want %h", dut_vec, exp_vec());
        end
        cycle(1, 0, 2'b10, 6'd40, 1, 1, 1);
        n_vec++;
        if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL range_mixed got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_multi_reset();
        cycle(1, 0, 2'b01, 6'd23, 1, 1, 1);
        cycle(1, 0, 2'b01, 6'd23, 1, 1, 1);
        n_vec++;
        if (dut_vec !== exp_vec() || hour !== 5'd23 || min !== 6'd23 || sec !== 6'd23) begin
            n_err++;
            $display("FAIL multi_enable got %h want %h", dut_vec, exp_vec());
        end
        cycle(0, 1, 2'b01, 6'd17, 1, 1, 1);
        n_vec++;
        if (dut_vec !== 19'd0) begin
            n_err++;
            $display("FAIL reset_priority got %h want %h", dut_vec, 19'd0);
        end
    endtask

    task automatic test_mode_latency();
        load_time(5, 6, 7);
        cycle(1, 0, 2'b00, 6'd0, 0, 0, 0);
        cycle(1, 0, 2'b00, 6'd0, 0, 0, 0);
        cycle(1, 1, 2'b01, 6'd0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || sec !== 6'd8) begin
            n_err++;
            $display("FAIL latency_run_to_set got %h want %h", dut_vec, exp_vec());
        end
        cycle(1, 0, 2'b01, 6'd0, 0, 0, 0);
        cycle(1, 1, 2'b00, 6'd0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== exp_vec() || sec !== 6'd8) begin
            n_err++;
            $display("FAIL latency_set_to_run got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [1:0] st;
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            cycle(($urandom_range(0, 99) != 0), 1'($urandom), st, 6'($urandom_range(0, 63)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0));
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random_%0d got %h want %h", i, dut_vec, exp_vec());
            end
`ifdef HMS_HOURLY_CHIME_EN
            n_vec++;
            if (chime !== m_chime) begin
                n_err++;
                $display("FAIL random_chime_%0d got %b want %b", i, chime, m_chime);
            end
`endif
        end
        // Run long stretches from near the top of an hour to exercise carries.
        load_time(22, 59, 50);
        cycle(1, 0, 2'b00, 6'd0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            cycle(1, 1, 2'b00, 6'd0, 0, 0, 0);
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL run_%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_pause();
        test_range();
        test_multi_reset();
        test_mode_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hms_timekeeper.md
Name: hms_timekeeper

Overview:
- Downstream consumer of the time-setting stage: holds the running hour/minute/second registers of the clock chip.
- Advances on a 1 Hz tick in run mode; loads set values in set modes; clears in clear mode.
- Merges the roles of the separate counter_60sec/counter_60min/counter_24h stages into one synchronous block, with carries between fields.
- Registered outputs drive the display/BCD stage.

Parameters:
- SEC_MAX, 59, terminal count of the seconds field.
- MIN_MAX, 59, terminal count of the minutes field.
- HOUR_MAX, 23, terminal count of the hours field (11 gives a 0-11 clock).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- tick  in  1  one-clk-wide 1 Hz enable pulse from the prescaler.
- state  in  2  mode: 00 run, 01 set/pause, 10 set/pause, 11 clear.
- num  in  6  value to load in set modes.
- sec_enable  in  1  load num into seconds.
- min_enable  in  1  load num into minutes.
- hour_enable  in  1  load num into hours.
- sec  out  6  seconds, 0..SEC_MAX.
- min  out  6  minutes, 0..MIN_MAX.
- hour  out  5  hours, 0..HOUR_MAX.
- day_carry  out  1  one-clk pulse on wrap from max time to 00:00:00.
- set_err  out  1  one-clk pulse when a load is rejected as out of range.

Behaviour:
- Reset, sampled when rst=0 at a clk edge:
  - sec, min, hour, day_carry, set_err all become 0.
  - Reset has priority over every other input, including mid-load and mid-wrap.
- Mode register:
  - state is registered internally (mode_q); mode_q drives all decisions, so each mode takes effect one clk after state changes.
  - Reset value of mode_q is 00.
- RUN (mode_q=00), per clk with tick=1:
  - sec increments.
  - If sec==SEC_MAX: sec->0 and min increments.
  - If min also ==MIN_MAX: min->0 and hour increments.
  - If hour also ==HOUR_MAX: hour->0 and day_carry=1 in that same cycle.
  - Update is visible on outputs one clk after the tick cycle.
  - tick=0: all fields hold.
  - Enables are ignored in RUN.
- SET (mode_q=01 or 10):
  - Counting is halted, and ticks are ignored. This is the pause function.
  - On each clk, each field whose enable is 1 loads num, provided it is in range: num<=SEC_MAX, num<=MIN_MAX, num<=HOUR_MAX respectively.
  - hour loads num[4:0] and requires num[5]==0 as well as num[4:0]<=HOUR_MAX.
  - Multiple enables load the same num into each selected field. Each field is checked independently: valid ones load, invalid ones hold.
  - Any rejected field sets set_err=1 for that cycle only.
  - Enables are level-sensitive: a held enable reloads every cycle, with no side effects.
  - No carries occur in SET.
- CLEAR (mode_q=11):
  - sec, min, hour forced to 0 every cycle; ticks and enables are ignored.
  - day_carry stays 0.
- Leaving SET or CLEAR for RUN:
  - Counting resumes from the held values on the first tick after mode_q=00.
  - A tick coincident with the mode change is judged against the old mode_q.
- day_carry and set_err default to 0 in every cycle they are not asserted.
- Arithmetic is unsigned with no saturation; fields can never hold out-of-range values.

Optional Feature:
- Macro: HMS_HOURLY_CHIME_EN.
- When defined:
  - Adds output chime (1 bit, reset 0).
  - chime=1 for one clk whenever hour increments or wraps in RUN because of a tick, i.e. at every mm:ss 59:59 -> 00:00 rollover, including the midnight rollover.
  - No chime on SET loads or CLEAR.
- When undefined: the chime port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hms_pkg holds:
  - mode constants MODE_RUN=2'b00, MODE_SET_A=2'b01, MODE_SET_B=2'b10, MODE_CLEAR=2'b11;
  - field widths SEC_W=6, HOUR_W=5.
- One natural sub-module, hms_field_cnt, instantiated three times. It is a mod-(MAX+1) counter with:
  - inputs: inc, load, load value, clear;
  - outputs: value, a terminal-count flag for the carry chain, and a range-reject flag.

Test Plan:
- Reset and clear:
  - Drive rst=0 for 2 clk with arbitrary inputs -> sec/min/hour=0, day_carry=0, set_err=0.
  - Then mode 11 with ticks -> fields stay 0.
- Rollover:
  - SET loads hour=23, min=59, sec=58, then mode 00 and 2 ticks.
  - Required: 23:59:59, then 00:00:00 with day_carry=1 for exactly that one cycle.
  - With HMS_HOURLY_CHIME_EN, chime=1 in the same cycle.
- Pause:
  - From 10:20:30 in RUN, switch to mode 01 and apply 5 ticks -> time stays 10:20:30.
  - Return to 00 and apply 1 tick -> 10:20:31.
- Range check:
  - In SET, num=60 with sec_enable=1 -> sec unchanged, set_err=1 for one clk.
  - num=24 with hour_enable=1 -> hour unchanged, set_err=1.
  - num=59 with min_enable=1 -> min=59, set_err=0.
- Multi-enable and reset priority:
  - num=23 with hour/min/sec enables all high -> hour=23, min=23, sec=23.
  - Assert rst=0 in the same cycle as a load -> all fields 0.
- Mode latency:
  - A tick in the same cycle state changes 00->01 -> that tick still counts.
  - A tick in the same cycle state changes 01->00 -> that tick is ignored.
